// File: rtl/audio_pio_pkg.sv
// rtl/audio_pio_pkg.sv - shared constants and helpers for the audio input PIO
package audio_pio_pkg;

    // Avalon word addresses of the register map
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // Edge-capture selection encodings
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Picks the edge event that feeds edge_capture for a given EDGE_TYPE
    function automatic logic edge_select(input int edge_type, input logic rise, input logic fall);
        case (edge_type)
            EDGE_RISE: edge_select = rise;
            EDGE_FALL: edge_select = fall;
            default:   edge_select = rise | fall;
        endcase
    endfunction

endpackage

// File: rtl/audio_pio_filter.sv
// rtl/audio_pio_filter.sv - per-line synchroniser, debounce filter and edge detector
module audio_pio_filter
    import audio_pio_pkg::*;
#(
    parameter int EDGE_TYPE = 0,
    parameter int DEBOUNCE  = 0,
    parameter int CNT_W     = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_in,
    output logic o_filt,
    output logic o_edge
);

    logic r_sync1;
    logic r_sync2;
    logic r_filt;
    logic r_filt_d;
    logic w_rise;
    logic w_fall;

    // Two-flop synchroniser for the asynchronous input line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_in;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE == 0) begin : g_bypass
            // No filtering: the filtered value is just one more register stage
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_filt <= 1'b0;
                end else begin
                    r_filt <= r_sync2;
                end
            end
        end else begin : g_debounce
            logic [CNT_W-1:0] r_cnt;

            // Accept a new level only after DEBOUNCE consecutive differing samples
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt  <= '0;
                    r_filt <= 1'b0;
                end else if (r_sync2 == r_filt) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_W'(DEBOUNCE - 1)) begin
                    r_filt <= r_sync2;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    // Delayed copy of the filtered value for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filt_d <= 1'b0;
        end else begin
            r_filt_d <= r_filt;
        end
    end

    assign w_rise = r_filt & ~r_filt_d;
    assign w_fall = ~r_filt & r_filt_d;
    assign o_filt = r_filt;
    assign o_edge = edge_select(EDGE_TYPE, w_rise, w_fall);

endmodule

// File: rtl/audio_in_pio.sv
// rtl/audio_in_pio.sv - Avalon-MM input PIO with debounce, edge capture and level IRQ
module audio_in_pio
    import audio_pio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = 0,
    parameter int DEBOUNCE  = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // Reject parameter sets the datapath cannot represent
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $fatal(1, "audio_in_pio: WIDTH must be within 1..32");
        end
        if (DEBOUNCE < 0 || DEBOUNCE > 65535) begin : g_bad_debounce
            $fatal(1, "audio_in_pio: DEBOUNCE must be within 0..65535");
        end
        if (CNT_W < 1 || CNT_W > 32 || (longint'(1) << CNT_W) <= longint'(DEBOUNCE)) begin : g_bad_cnt_w
            $fatal(1, "audio_in_pio: CNT_W too small for DEBOUNCE");
        end
    endgenerate

    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge;

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_line
            audio_pio_filter #(
                .EDGE_TYPE (EDGE_TYPE),
                .DEBOUNCE  (DEBOUNCE),
                .CNT_W     (CNT_W)
            ) u_filter (
                .clk     (clk),
                .reset_n (reset_n),
                .i_in    (in_port[g]),
                .o_filt  (w_filt[g]),
                .o_edge  (w_edge[g])
            );
        end
        if (WIDTH < 32) begin : g_wd_upper
            logic w_unused_wd;
            assign w_unused_wd = ^writedata[31:WIDTH];
        end
    endgenerate

    assign w_wr  = chipselect & ~write_n;
    assign w_clr = (w_wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    // Interrupt mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
        end else if (w_wr && address == ADDR_MASK) begin
            r_mask <= writedata[WIDTH-1:0];
        end
    end

    // Sticky edge capture; a new edge overrides a same-cycle clear of that bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge <= '0;
        end else begin
            r_edge <= (r_edge & ~w_clr) | w_edge;
        end
    end

    // Registered read mux, updated every cycle regardless of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                ADDR_DATA: readdata <= 32'(w_filt);
                ADDR_RSVD: readdata <= '0;
                ADDR_MASK: readdata <= 32'(r_mask);
                default:   readdata <= 32'(r_edge);
            endcase
        end
    end

    assign irq = |(r_edge & r_mask);

endmodule
